// File: rtl/imem_fetch_resp_if.sv
// Fetch/load bus of the instruction-memory responder.
// With IMEM_PARITY_EN defined the bus also carries par_err_IM_ID.
interface imem_fetch_resp_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [15:0]     pc;
    logic            stall_IM_ID;
    logic            flush_IM_ID;
    logic [15:0]     instr_IM_ID;
    logic            oor_IM_ID;
    logic            imem_busy;
    logic            ld_start;
    logic [ADDR_W:0] ld_len;
    logic [15:0]     ld_data;
    logic            ld_vld;
    logic            ld_rdy;
    logic            ld_done;
`ifdef IMEM_PARITY_EN
    logic            par_err_IM_ID;

    modport master (
        output pc, stall_IM_ID, flush_IM_ID, ld_start, ld_len, ld_data, ld_vld,
        input  instr_IM_ID, oor_IM_ID, imem_busy, ld_rdy, ld_done, par_err_IM_ID
    );
    modport slave (
        input  pc, stall_IM_ID, flush_IM_ID, ld_start, ld_len, ld_data, ld_vld,
        output instr_IM_ID, oor_IM_ID, imem_busy, ld_rdy, ld_done, par_err_IM_ID
    );
`else
    modport master (
        output pc, stall_IM_ID, flush_IM_ID, ld_start, ld_len, ld_data, ld_vld,
        input  instr_IM_ID, oor_IM_ID, imem_busy, ld_rdy, ld_done
    );
    modport slave (
        input  pc, stall_IM_ID, flush_IM_ID, ld_start, ld_len, ld_data, ld_vld,
        output instr_IM_ID, oor_IM_ID, imem_busy, ld_rdy, ld_done
    );
`endif
endinterface

// File: rtl/imem_fetch_resp.sv
// Instruction memory with registered IM_ID fetch output and a host program-load FSM.
// Optional IMEM_PARITY_EN adds a per-word even-parity bit and par_err_IM_ID.
module imem_fetch_resp #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [15:0] NOP_INSTR = 16'hF000
) (
    input logic               clk,
    input logic               rst_n,
    imem_fetch_resp_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
`ifdef IMEM_PARITY_EN
    localparam int unsigned WORD_W = 17;
`else
    localparam int unsigned WORD_W = 16;
`endif

    typedef enum logic {RUN, LOAD} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [15:0]       instr_q, instr_d;
    logic              oor_q, oor_d;
    logic              done_q, done_d;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd_word_c;
    logic [WORD_W-1:0] wr_word_c;
    logic              pc_oor_c;
    logic              ld_rdy_c;
    logic              wr_en_c;

`ifdef IMEM_PARITY_EN
    logic              par_q, par_d;
    assign wr_word_c = {^bus.ld_data, bus.ld_data};
`else
    assign wr_word_c = bus.ld_data;
`endif

    assign pc_oor_c  = (bus.pc >> ADDR_W) != 16'd0;
    assign rd_word_c = mem_q[bus.pc[ADDR_W-1:0]];
    assign ld_rdy_c  = (state_q == LOAD) && (cnt_q < len_q);
    assign wr_en_c   = ld_rdy_c && bus.ld_vld;

    // Next-state, load counter and IM_ID register update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        instr_d = instr_q;
        oor_d   = oor_q;
        done_d  = 1'b0;
`ifdef IMEM_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            RUN: begin
                if (bus.flush_IM_ID) begin
                    instr_d = NOP_INSTR;
                    oor_d   = 1'b0;
`ifdef IMEM_PARITY_EN
                    par_d   = 1'b0;
`endif
                end else if (!bus.stall_IM_ID) begin
                    if (pc_oor_c) begin
                        instr_d = NOP_INSTR;
                        oor_d   = 1'b1;
`ifdef IMEM_PARITY_EN
                        par_d   = 1'b0;
`endif
                    end else begin
                        instr_d = rd_word_c[15:0];
                        oor_d   = 1'b0;
`ifdef IMEM_PARITY_EN
                        par_d   = ^rd_word_c;
`endif
                    end
                end
                // Entering LOAD presents a bubble so every busy cycle shows NOP
                if (bus.ld_start) begin
                    state_d = LOAD;
                    len_d   = bus.ld_len;
                    cnt_d   = CNT_W'(0);
                    instr_d = NOP_INSTR;
                    oor_d   = 1'b0;
`ifdef IMEM_PARITY_EN
                    par_d   = 1'b0;
`endif
                end
            end
            LOAD: begin
                instr_d = NOP_INSTR;
                oor_d   = 1'b0;
`ifdef IMEM_PARITY_EN
                par_d   = 1'b0;
`endif
                if (len_q == CNT_W'(0)) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end else if (wr_en_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= CNT_W'(0);
            len_q   <= CNT_W'(0);
            instr_q <= NOP_INSTR;
            oor_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef IMEM_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            instr_q <= instr_d;
            oor_q   <= oor_d;
            done_q  <= done_d;
`ifdef IMEM_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Storage array is not reset so it maps onto RAM macros
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[cnt_q[ADDR_W-1:0]] <= wr_word_c;
        end
    end

    assign bus.instr_IM_ID = instr_q;
    assign bus.oor_IM_ID   = oor_q;
    assign bus.imem_busy   = (state_q == LOAD);
    assign bus.ld_rdy      = ld_rdy_c;
    assign bus.ld_done     = done_q;
`ifdef IMEM_PARITY_EN
    assign bus.par_err_IM_ID = par_q;
`endif

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Directed bench for imem_fetch_resp: load sequences, fetch vector table, mid-load reset.
module tb_imem_fetch_resp;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    imem_fetch_resp_if #(.ADDR_W(12)) ifc ();

    imem_fetch_resp #(.ADDR_W(12), .NOP_INSTR(16'hF000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    typedef struct {
        logic [15:0] pc;
        logic        stall;
        logic        flush;
        logic [15:0] exp_instr;
        logic        exp_oor;
        logic        chk_instr;
    } vec_t;

    vec_t        vecs [13];
    logic [15:0] words [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] pc, input logic [15:0] exp, input string name);
        ifc.pc = pc;
        tick();
        chk(name, 32'(ifc.instr_IM_ID), 32'(exp));
    endtask

    initial begin
        vecs[0]  = '{16'h0000, 1'b0, 1'b0, 16'h1111, 1'b0, 1'b1};
        vecs[1]  = '{16'h0001, 1'b0, 1'b0, 16'h2222, 1'b0, 1'b1};
        vecs[2]  = '{16'h0002, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b1};
        vecs[3]  = '{16'h0003, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b1};
        vecs[4]  = '{16'h0002, 1'b1, 1'b1, 16'hF000, 1'b0, 1'b1};
        vecs[5]  = '{16'h0002, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b1};
        vecs[6]  = '{16'h0003, 1'b0, 1'b0, 16'h4444, 1'b0, 1'b1};
        vecs[7]  = '{16'h1000, 1'b0, 1'b0, 16'hF000, 1'b1, 1'b1};
        vecs[8]  = '{16'h0000, 1'b1, 1'b0, 16'hF000, 1'b1, 1'b1};
        vecs[9]  = '{16'h0FFF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{16'hFFFF, 1'b0, 1'b0, 16'hF000, 1'b1, 1'b1};
        vecs[11] = '{16'h0000, 1'b0, 1'b1, 16'hF000, 1'b0, 1'b1};
        vecs[12] = '{16'h0000, 1'b0, 1'b0, 16'h1111, 1'b0, 1'b1};
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        words[3] = 16'h4444;

        rst_n           = 1'b0;
        ifc.pc          = 16'h0000;
        ifc.stall_IM_ID = 1'b0;
        ifc.flush_IM_ID = 1'b0;
        ifc.ld_start    = 1'b0;
        ifc.ld_len      = '0;
        ifc.ld_data     = 16'h0000;
        ifc.ld_vld      = 1'b0;
        #12;
        chk("rst_instr", 32'(ifc.instr_IM_ID), 32'hF000);
        chk("rst_oor",   32'(ifc.oor_IM_ID),   32'h0);
        chk("rst_busy",  32'(ifc.imem_busy),   32'h0);
        chk("rst_rdy",   32'(ifc.ld_rdy),      32'h0);
        chk("rst_done",  32'(ifc.ld_done),     32'h0);
        rst_n = 1'b1;
        tick();

        // Four-word load with valid gaps and an ignored ld_start mid-load
        ifc.ld_start = 1'b1;
        ifc.ld_len   = 13'd4;
        tick();
        ifc.ld_start = 1'b0;
        chk("ld_enter_busy",  32'(ifc.imem_busy),   32'h1);
        chk("ld_enter_rdy",   32'(ifc.ld_rdy),      32'h1);
        chk("ld_enter_instr", 32'(ifc.instr_IM_ID), 32'hF000);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 1) begin
                ifc.ld_vld = 1'b0;
                if (i == 1) begin
                    ifc.ld_start = 1'b1;
                    ifc.ld_len   = 13'd0;
                end
                tick();
                ifc.ld_start = 1'b0;
                chk("ld_gap_rdy",   32'(ifc.ld_rdy),      32'h1);
                chk("ld_gap_busy",  32'(ifc.imem_busy),   32'h1);
                chk("ld_gap_instr", 32'(ifc.instr_IM_ID), 32'hF000);
            end
            ifc.ld_vld  = 1'b1;
            ifc.ld_data = words[i];
            tick();
            if (i < 3) begin
                chk("ld_mid_rdy",  32'(ifc.ld_rdy),    32'h1);
                chk("ld_mid_busy", 32'(ifc.imem_busy), 32'h1);
                chk("ld_mid_done", 32'(ifc.ld_done),   32'h0);
            end else begin
                chk("ld_end_busy", 32'(ifc.imem_busy), 32'h0);
                chk("ld_end_rdy",  32'(ifc.ld_rdy),    32'h0);
                chk("ld_end_done", 32'(ifc.ld_done),   32'h1);
            end
        end
        ifc.ld_vld = 1'b0;
        tick();
        chk("ld_done_pulse", 32'(ifc.ld_done), 32'h0);

        for (int i = 0; i < 13; i++) begin
            ifc.pc          = vecs[i].pc;
            ifc.stall_IM_ID = vecs[i].stall;
            ifc.flush_IM_ID = vecs[i].flush;
            tick();
            if (vecs[i].chk_instr)
                chk($sformatf("vec%0d_instr", i), 32'(ifc.instr_IM_ID), 32'(vecs[i].exp_instr));
            chk($sformatf("vec%0d_oor", i), 32'(ifc.oor_IM_ID), 32'(vecs[i].exp_oor));
        end
        ifc.stall_IM_ID = 1'b0;
        ifc.flush_IM_ID = 1'b0;

`ifdef IMEM_PARITY_EN
        dut.mem_q[1][16] = ~dut.mem_q[1][16];
        fetch(16'h0000, 16'h1111, "par_a0_instr");
        chk("par_a0_err", 32'(ifc.par_err_IM_ID), 32'h0);
        fetch(16'h0001, 16'h2222, "par_a1_instr");
        chk("par_a1_err", 32'(ifc.par_err_IM_ID), 32'h1);
`endif

        // Zero-length load: done pulse, no ready, memory untouched
        ifc.ld_start = 1'b1;
        ifc.ld_len   = 13'd0;
        ifc.ld_vld   = 1'b1;
        ifc.ld_data  = 16'hDEAD;
        tick();
        ifc.ld_start = 1'b0;
        chk("len0_busy", 32'(ifc.imem_busy), 32'h1);
        chk("len0_rdy",  32'(ifc.ld_rdy),    32'h0);
        chk("len0_done", 32'(ifc.ld_done),   32'h0);
        tick();
        ifc.ld_vld = 1'b0;
        chk("len0_done2", 32'(ifc.ld_done),   32'h1);
        chk("len0_busy2", 32'(ifc.imem_busy), 32'h0);
        fetch(16'h0000, 16'h1111, "len0_mem0");

        // Reset after two of four words: partial contents kept, no done
        ifc.ld_start = 1'b1;
        ifc.ld_len   = 13'd4;
        tick();
        ifc.ld_start = 1'b0;
        ifc.ld_vld   = 1'b1;
        ifc.ld_data  = 16'hAAAA;
        tick();
        ifc.ld_data  = 16'hBBBB;
        tick();
        chk("rstld_rdy_pre", 32'(ifc.ld_rdy), 32'h1);
        ifc.ld_data = 16'hCCCC;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstld_busy",  32'(ifc.imem_busy),   32'h0);
        chk("rstld_rdy",   32'(ifc.ld_rdy),      32'h0);
        chk("rstld_instr", 32'(ifc.instr_IM_ID), 32'hF000);
        ifc.ld_vld = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstld_no_done", 32'(ifc.ld_done), 32'h0);
        end
        fetch(16'h0000, 16'hAAAA, "rstld_mem0");
        fetch(16'h0001, 16'hBBBB, "rstld_mem1");
        fetch(16'h0002, 16'h3333, "rstld_mem2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_fetch_resp.md
Name: imem_fetch_resp

Overview:
- Instruction-memory responder for the 5-stage pipeline. Receives the PC-generated fetch address and returns the instruction word, registered into the IM_ID stage.
- Honours pipeline stall and branch/jump flush: a flush injects a NOP bubble.
- Contains a program-load state machine. A host streams words into the memory over a valid/ready handshake, and the core is held in stall during the load.

Parameters:
- ADDR_W, 12, word-address width of memory; depth = 2^ADDR_W words of 16 bits.
- NOP_INSTR, 16'hF000, encoding driven on instr_IM_ID for bubbles, reset and load.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- pc  input  16  fetch address from program counter
- stall_IM_ID  input  1  pipeline stall; hold IM_ID register
- flush_IM_ID  input  1  flow change taken in EX; squash fetched instruction
- instr_IM_ID  output  16  registered instruction to ID stage
- oor_IM_ID  output  1  registered flag: fetched pc was outside memory
- imem_busy  output  1  stall request to PC/hazard logic while loading
- ld_start  input  1  single-cycle pulse; begin program load at address 0
- ld_len  input  ADDR_W+1  number of words to load (0..2^ADDR_W)
- ld_data  input  16  load word
- ld_vld  input  1  ld_data valid
- ld_rdy  output  1  block accepts ld_data this cycle
- ld_done  output  1  one-cycle pulse when load completes

Behaviour:
- Reset values: state RUN, instr_IM_ID=NOP_INSTR, oor_IM_ID=0, imem_busy=0, ld_rdy=0, ld_done=0, load counter=0. Memory array is not reset.
- Fetch (state RUN): the IM_ID register updates on each clk edge, with the following priority.
  - flush_IM_ID=1: instr_IM_ID<=NOP_INSTR, oor_IM_ID<=0. Flush wins over stall.
  - else stall_IM_ID=1: hold instr_IM_ID and oor_IM_ID.
  - else pc[15:ADDR_W]!=0: instr_IM_ID<=NOP_INSTR, oor_IM_ID<=1.
  - else: instr_IM_ID<=mem[pc[ADDR_W-1:0]], oor_IM_ID<=0.
- Fetch latency is 1 clk: pc presented in cycle N is visible on instr_IM_ID after edge N+1.
- State machine, states RUN and LOAD:
  - RUN -> LOAD on ld_start=1. Latch ld_len and clear the counter.
  - If latched ld_len=0: go straight back to RUN next cycle with ld_done=1 and no writes. In that LOAD cycle ld_rdy=0.
  - ld_start while in LOAD is ignored.
- LOAD behaviour:
  - imem_busy=1 combinationally in LOAD. ld_rdy=1 in LOAD while count<len.
  - On ld_vld&ld_rdy: mem[count]<=ld_data, count<=count+1.
  - The write of word len-1 transitions to RUN on the same edge; ld_done is a registered pulse for exactly that following cycle.
  - ld_vld without ld_rdy is ignored and no data is consumed. Data is held by the source until accepted.
  - instr_IM_ID is forced to NOP_INSTR and oor_IM_ID to 0 for every LOAD cycle. The first fetch after load completes reads the new contents.
- Counter width is ADDR_W+1, so ld_len=2^ADDR_W fills the memory exactly with no wrap.
- Reset mid-load: return to RUN, busy/rdy deasserted. Already-written words remain; the partial load is not signalled as done.
- No read-during-write hazard exists, because reads are suppressed during LOAD.
- Memory: synchronous-write, synchronous-read-into-IM_ID, inferable as block RAM.

Optional Feature:
- IMEM_PARITY_EN defined:
  - Each word stores an extra even-parity bit computed on write.
  - A fetch is checked: output par_err_IM_ID (1 bit, registered, reset 0) is asserted alongside a mismatched instruction.
  - par_err_IM_ID is held on stall, cleared on flush/NOP.
  - The instruction is still delivered unmodified.
- IMEM_PARITY_EN undefined: no parity storage, no par_err_IM_ID port.

Test Plan:
- Load: ld_start, ld_len=4, words 16'h1111,2222,3333,4444 with ld_vld gaps -> ld_rdy high for 4 accepts, imem_busy high throughout, ld_done one pulse after 4th accept, instr_IM_ID=16'hF000 during LOAD.
- Fetch: pc=0,1,2,3 consecutive -> instr_IM_ID=1111,2222,3333,4444, each one cycle after its pc.
- Stall/flush: stall_IM_ID=1 while pc=2 -> instr_IM_ID holds 2222. Then flush_IM_ID=1 together with stall -> instr_IM_ID=16'hF000 next cycle.
- Out of range: ADDR_W=12, pc=16'h1000 -> instr_IM_ID=16'hF000, oor_IM_ID=1; pc=16'h0FFF -> oor_IM_ID=0.
- Boundaries:
  - ld_len=0 -> ld_done pulse within 2 cycles, no ld_rdy, memory unchanged.
  - ld_start during LOAD is ignored.
  - rst_n low after 2 of 4 words -> RUN, ld_done never pulses, words 0-1 readable.
- With IMEM_PARITY_EN: force-flip a stored bit at address 1 -> fetch pc=1 gives par_err_IM_ID=1; address 0 gives 0.
